muldiv_ctrl: RTL and testbench



---
 rtl/muldiv_ctrl_pkg.sv | 26 ++
 rtl/muldiv_signfix.sv | 22 ++
 rtl/muldiv_ctrl.sv | 105 ++++++++++
 tb/tb_muldiv_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_ctrl_pkg.sv
// muldiv_ctrl_pkg: op and state encodings shared by the mul/div sequencer and E-stage decode
package muldiv_ctrl_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MUL   = 3'd4
    } md_op_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HOLD
    } md_state_t;

    function automatic logic op_is_div(input md_op_t op);
        return op == MD_DIV || op == MD_DIVU;
    endfunction

    function automatic logic op_is_signed(input md_op_t op);
        return op == MD_MULT || op == MD_DIV || op == MD_MUL;
    endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// muldiv_signfix: two's-complement negation of a 64-bit word, either whole or as independent 32-bit halves
module muldiv_signfix (
    input  logic [63:0] x,
    input  logic        wide,
    input  logic        neg_hi,
    input  logic        neg_lo,
    output logic [63:0] y
);

    logic [31:0] hi;
    logic [31:0] lo;
    logic [63:0] whole;

    // In wide mode neg_hi negates the full 64-bit value (product fixup)
    always_comb begin
        hi    = neg_hi ? -x[63:32] : x[63:32];
        lo    = neg_lo ? -x[31:0] : x[31:0];
        whole = neg_hi ? -x : x;
        y     = wide ? whole : {hi, lo};
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: E-stage sequencer for iterative mul/div units with sign-magnitude pre/post fixup
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic        flush,
    input  logic        advance,
    output logic        stall,
    output logic        res_valid,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        hi_we,
    output logic        lo_we,
    output logic        mul_valid,
    output logic        div_valid,
    output logic [31:0] op_a,
    output logic [31:0] op_b,
    input  logic        mul_done,
    input  logic        div_done,
    input  logic [63:0] mul_c,
    input  logic [63:0] div_c
);

    md_state_t   state, state_n;
    md_op_t      op, req_md;
    logic        neg_q, neg_r;
    logic        start, div0, unit_done, cap;
    logic [63:0] pre, post;

    assign req_md    = md_op_t'(req_op);
    assign div0      = op_is_div(req_md) && req_b == 32'd0;
    assign start     = state == IDLE && req_valid && !flush;
    assign unit_done = op_is_div(op) ? div_done : mul_done;
    assign cap       = state == RUN && unit_done && !flush;

    muldiv_signfix u_pre (
        .x      ({req_a, req_b}),
        .wide   (1'b0),
        .neg_hi (op_is_signed(req_md) && req_a[31]),
        .neg_lo (op_is_signed(req_md) && req_b[31]),
        .y      (pre)
    );

    // Divider: hi is remainder (sign of dividend), lo is quotient
    muldiv_signfix u_post (
        .x      (op_is_div(op) ? div_c : mul_c),
        .wide   (!op_is_div(op)),
        .neg_hi (op_is_div(op) ? neg_r : neg_q),
        .neg_lo (neg_q),
        .y      (post)
    );

    always_comb begin
        state_n = state;
        if (flush)
            state_n = IDLE;
        else if (start)
            state_n = div0 ? HOLD : RUN;
        else if (cap)
            state_n = HOLD;
        else if (state == HOLD && advance)
            state_n = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            op        <= MD_MULT;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            op_a      <= 32'd0;
            op_b      <= 32'd0;
            mul_valid <= 1'b0;
            div_valid <= 1'b0;
            res_hi    <= 32'd0;
            res_lo    <= 32'd0;
        end else begin
            state     <= state_n;
            mul_valid <= state_n == RUN && (start ? !op_is_div(req_md) : mul_valid);
            div_valid <= state_n == RUN && (start ? op_is_div(req_md) : div_valid);
            if (start) begin
                op    <= req_md;
                neg_q <= op_is_signed(req_md) && (req_a[31] ^ req_b[31]);
                neg_r <= req_md == MD_DIV && req_a[31];
                op_a  <= pre[63:32];
                op_b  <= pre[31:0];
                if (div0)
                    {res_hi, res_lo} <= {req_a, 32'hFFFF_FFFF};
            end
            if (cap)
                {res_hi, res_lo} <= post;
        end
    end

    assign res_valid = state == HOLD;
    assign hi_we     = res_valid && op != MD_MUL;
    assign lo_we     = res_valid && op != MD_MUL;
    assign stall     = req_valid && state != HOLD;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: scoreboard bench for muldiv_ctrl with behavioural mul/div unit responders
module tb_muldiv_ctrl;
    import muldiv_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset, req_valid, flush, advance, mul_done, div_done;
    logic [2:0]  req_op;
    logic [31:0] req_a, req_b;
    logic [63:0] mul_c, div_c;
    logic        stall, res_valid, hi_we, lo_we, mul_valid, div_valid;
    logic [31:0] res_hi, res_lo, op_a, op_b;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        we;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    muldiv_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .flush     (flush),
        .advance   (advance),
        .stall     (stall),
        .res_valid (res_valid),
        .res_hi    (res_hi),
        .res_lo    (res_lo),
        .hi_we     (hi_we),
        .lo_we     (lo_we),
        .mul_valid (mul_valid),
        .div_valid (div_valid),
        .op_a      (op_a),
        .op_b      (op_b),
        .mul_done  (mul_done),
        .div_done  (div_done),
        .mul_c     (mul_c),
        .div_c     (div_c)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t               e;
        logic [63:0]        r;
        logic signed [31:0] sa, sbv;
        sa   = a;
        sbv  = b;
        e.we = op != 3'(MD_MUL);
        if (op == 3'(MD_MULTU))
            r = {32'd0, a} * {32'd0, b};
        else if ((op == 3'(MD_DIV) || op == 3'(MD_DIVU)) && b == 32'd0)
            r = {a, 32'hFFFF_FFFF};
        else if (op == 3'(MD_DIVU))
            r = {a % b, a / b};
        else if (op == 3'(MD_DIV) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            r = {32'd0, 32'h8000_0000};
        else if (op == 3'(MD_DIV))
            r = {32'(sa % sbv), 32'(sa / sbv)};
        else
            r = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        e.hi = r[63:32];
        e.lo = r[31:0];
        return e;
    endfunction

    function automatic logic [31:0] mag(input logic [31:0] v, input bit sgn);
        return (sgn && v[31]) ? -v : v;
    endfunction

    task automatic check_all_zero(input string tag);
        check(tag, {32'd0, stall, res_valid, hi_we, lo_we, mul_valid, div_valid}, 64'd0);
        check({tag, "_ops"}, {op_a, op_b}, 64'd0);
        check({tag, "_res"}, {res_hi, res_lo}, 64'd0);
    endtask

    // Issues one request and plays both units; chain=1 means we are in HOLD and advance with the new request
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int lat, input bit chain);
        int   off, res_at, k, first_v;
        bit   sgn, dz, bad_stall, dv_seen;
        exp_t e;
        off       = chain ? 1 : 0;
        sgn       = op == 3'(MD_MULT) || op == 3'(MD_DIV) || op == 3'(MD_MUL);
        dz        = (op == 3'(MD_DIV) || op == 3'(MD_DIVU)) && b == 32'd0;
        res_at    = dz ? off + 1 : off + 2 + lat;
        first_v   = -1;
        bad_stall = 0;
        dv_seen   = 0;
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        advance   = chain;
        sb.push_back(model(op, a, b));
        #1;
        if (!chain) check("stall_c0", stall, 1);
        for (k = 1; k <= 60; k++) begin
            @(negedge clk);
            advance = 1'b0;
            if (res_valid) break;
            if (!stall) bad_stall = 1;
            if ((mul_valid || div_valid) && first_v < 0) begin
                first_v = k;
                check("op_a", op_a, mag(a, sgn));
                check("op_b", op_b, mag(b, sgn));
            end
            if (mul_valid || div_valid) dv_seen = 1;
            // The idle unit also pulses done with junk to prove it is ignored
            mul_done = (mul_valid && k == off + 1 + lat) || (div_valid && k == off + 1);
            mul_c    = mul_valid ? {32'd0, op_a} * {32'd0, op_b} : 64'hDEAD_BEEF_0BAD_F00D;
            div_done = (div_valid && k == off + 1 + lat) || (mul_valid && k == off + 1);
            div_c    = div_valid ? {op_a % op_b, op_a / op_b} : 64'h0BAD_F00D_DEAD_BEEF;
        end
        mul_done = 1'b0;
        div_done = 1'b0;
        check("res_cycle", 64'(k), 64'(res_at));
        check("stall_run", 64'(bad_stall), 0);
        if (dz) check("div0_novalid", 64'(dv_seen), 0);
        else    check("valid_cycle", 64'(first_v), 64'(off + 1));
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("res_hi", res_hi, e.hi);
            check("res_lo", res_lo, e.lo);
            check("we", {hi_we, lo_we}, {e.we, e.we});
        end
        check("stall_hold", stall, 0);
    endtask

    task automatic retire();
        advance = 1'b1;
        @(negedge clk);
        advance   = 1'b0;
        req_valid = 1'b0;
        check("idle_after_adv", res_valid, 0);
    endtask

    initial begin
        logic [31:0] prev_lo;
        bit          rv_seen;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_op    = 3'd0;
        req_a     = 32'd0;
        req_b     = 32'd0;
        flush     = 1'b0;
        advance   = 1'b0;
        mul_done  = 1'b0;
        div_done  = 1'b0;
        mul_c     = 64'd0;
        div_c     = 64'd0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        @(negedge clk);

        run_op(3'(MD_MULT), -32'sd3, 32'd5, 4, 0);
        repeat (3) @(negedge clk);
        check("hold_no_restart", {res_valid, mul_valid, div_valid}, 3'b100);
        run_op(3'(MD_MULTU), 32'hFFFF_FFFF, 32'd2, 3, 1);
        retire();
        run_op(3'(MD_DIV), -32'sd7, 32'd2, 3, 0);
        retire();
        run_op(3'(MD_DIVU), 32'd7, 32'd2, 2, 0);
        retire();
        run_op(3'(MD_DIVU), 32'd9, 32'd0, 1, 0);
        retire();
        run_op(3'(MD_MUL), 32'd6, -32'sd7, 2, 0);
        retire();
        run_op(3'(MD_DIV), 32'h8000_0000, 32'hFFFF_FFFF, 5, 0);
        retire();
        run_op(3'(MD_DIV), -32'sd9, 32'd0, 1, 0);
        retire();
        run_op(3'(MD_MULT), 32'h8000_0000, 32'h8000_0000, 1, 0);
        retire();
        run_op(3'(MD_DIV), 32'd17, -32'sd5, 6, 0);
        retire();

        // flush in the middle of RUN, then a stale done in IDLE
        req_valid = 1'b1;
        req_op    = 3'(MD_DIVU);
        req_a     = 32'd100;
        req_b     = 32'd7;
        repeat (2) @(negedge clk);
        check("pre_flush_dv", div_valid, 1);
        flush     = 1'b1;
        req_valid = 1'b0;
        @(negedge clk);
        flush = 1'b0;
        check("flush_idle", {div_valid, res_valid}, 2'b00);
        div_done = 1'b1;
        div_c    = {32'd2, 32'd14};
        rv_seen  = 0;
        repeat (4) begin
            @(negedge clk);
            div_done = 1'b0;
            if (res_valid || div_valid) rv_seen = 1;
        end
        check("flush_no_result", 64'(rv_seen), 0);

        // flush on the same cycle as done
        prev_lo   = res_lo;
        req_valid = 1'b1;
        req_op    = 3'(MD_DIVU);
        req_a     = 32'd50;
        req_b     = 32'd5;
        repeat (3) @(negedge clk);
        div_done  = 1'b1;
        div_c     = {32'd0, 32'd10};
        flush     = 1'b1;
        req_valid = 1'b0;
        @(negedge clk);
        flush    = 1'b0;
        div_done = 1'b0;
        rv_seen  = res_valid;
        repeat (3) begin
            @(negedge clk);
            if (res_valid) rv_seen = 1;
        end
        check("flush_done_rv", 64'(rv_seen), 0);
        check("flush_done_lo", res_lo, prev_lo);

        // reset during RUN
        req_valid = 1'b1;
        req_op    = 3'(MD_MULT);
        req_a     = 32'd11;
        req_b     = -32'sd13;
        repeat (2) @(negedge clk);
        check("pre_reset_mv", mul_valid, 1);
        reset     = 1'b1;
        req_valid = 1'b0;
        @(negedge clk);
        check_all_zero("reset_run");
        reset = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
